uart_frame_parser: RTL and testbench

Store-and-forward framing stage between the UART receive path and the coprocessor. It consumes the raw byte stream from the UART core (`rx_out` byte plus the one-cycle `rx_char_received` pulse) and recognises frames of the form SYNC, LEN, LEN payload bytes, CSUM. Only payload from checksum-clean frames is released downstream, as a valid/ready byte stream with an end-of-frame marker. Malformed, oversize, stalled and corrupt frames are dropped and counted, so the coprocessor only ever sees complete, verified commands.

---
 rtl/uart_frame_pkg.sv | 20 ++
 rtl/frame_ring_buffer.sv | 52 +++++
 rtl/uart_frame_parser.sv | 132 +++++++++++++
 tb/tb_uart_frame_parser.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types for the UART framing stage: default sync byte, parser states,
// and the payload buffer entry (byte plus end-of-frame flag).
// Pure declarations; no logic, no latency, no flow control.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM
  } parser_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } buf_entry_t;

endpackage

// File: rtl/frame_ring_buffer.sv
// Payload ring buffer with speculative write, commit and rollback pointers.
// Latency: a committed entry is readable the cycle after commit; read is combinational.
// Backpressure: rd only advances on valid && ready; writer must check free before a frame.
module frame_ring_buffer
  import uart_frame_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  buf_entry_t    wr_entry,
  input  logic          commit,
  input  logic          rollback,
  input  logic          rd_ready,
  output buf_entry_t    rd_entry,
  output logic          rd_valid,
  output logic [PW-1:0] free
);

  buf_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] cm_q;
  logic [PW-1:0] rd_q;

  // Storage is not reset; entries are only observable between rd and cm.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= wr_entry;
  end

  // Pointer update: write/rollback move wr, commit snaps cm to wr, reads advance rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      cm_q <= '0;
      rd_q <= '0;
    end else begin
      if (rollback)   wr_q <= cm_q;
      else if (wr_en) wr_q <= wr_q + PW'(1);
      if (commit) cm_q <= wr_q;
      if (rd_valid && rd_ready) rd_q <= rd_q + PW'(1);
    end
  end

  // Only committed bytes are visible; output is forced to zero while empty.
  assign rd_valid = (rd_q != cm_q);
  assign rd_entry = rd_valid ? mem[rd_q[AW-1:0]] : '0;
  assign free     = PW'(DEPTH) - (wr_q - rd_q);

endmodule

// File: rtl/uart_frame_parser.sv
// Store-and-forward UART framer: SYNC, LEN, payload, XOR checksum; releases clean payload only.
// Latency: frame_ok/frame_err and dout_valid rise one cycle after the checksum byte.
// Backpressure: dout held while !dout_ready; frames that do not fit in free space are dropped.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC           = SYNC_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         DEPTH          = 32,
  parameter int         TIMEOUT_CYCLES = 1_033_400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic [7:0] dout,
  output logic       dout_last,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  parser_state_t state_q, state_n;
  logic [7:0]    rem_q;
  logic [7:0]    chk_q;
  logic [GW-1:0] gap_q;
  logic          timeout;
  logic          wr_en, commit, rollback, ok_ev, err_ev, load_len;
  buf_entry_t    wr_entry, rd_entry;
  logic [PW-1:0] free;

  assign timeout = (state_q != HUNT) && (gap_q == GW'(TIMEOUT_CYCLES));

  // Next-state and buffer strobes; timeout wins over a byte arriving in the same cycle.
  always_comb begin
    state_n       = state_q;
    wr_en         = 1'b0;
    commit        = 1'b0;
    rollback      = 1'b0;
    ok_ev         = 1'b0;
    err_ev        = 1'b0;
    load_len      = 1'b0;
    wr_entry.data = din;
    wr_entry.last = (rem_q == 8'd1);
    if (timeout) begin
      state_n  = HUNT;
      rollback = 1'b1;
      err_ev   = 1'b1;
    end else if (din_valid) begin
      case (state_q)
        HUNT: if (din == SYNC) state_n = LEN;
        LEN: begin
          if (din == 8'd0 || 32'(din) > MAX_LEN || 32'(din) > 32'(free)) begin
            err_ev  = 1'b1;
            state_n = HUNT;
          end else begin
            load_len = 1'b1;
            state_n  = PAYLOAD;
          end
        end
        PAYLOAD: begin
          wr_en = 1'b1;
          if (rem_q == 8'd1) state_n = CSUM;
        end
        CSUM: begin
          state_n = HUNT;
          if (din == chk_q) begin
            commit = 1'b1;
            ok_ev  = 1'b1;
          end else begin
            rollback = 1'b1;
            err_ev   = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= HUNT;
    else      state_q <= state_n;
  end

  // Remaining-byte counter, running checksum, gap timer, status pulses and error count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q     <= '0;
      chk_q     <= '0;
      gap_q     <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      if (load_len) begin
        rem_q <= din;
        chk_q <= din;
      end else if (wr_en) begin
        rem_q <= rem_q - 8'd1;
        chk_q <= chk_q ^ din;
      end
      if (state_q == HUNT || din_valid || timeout) gap_q <= '0;
      else                                         gap_q <= gap_q + GW'(1);
      frame_ok  <= ok_ev;
      frame_err <= err_ev;
      if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  frame_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_entry (wr_entry),
    .commit   (commit),
    .rollback (rollback),
    .rd_ready (dout_ready),
    .rd_entry (rd_entry),
    .rd_valid (dout_valid),
    .free     (free)
  );

  assign dout      = rd_entry.data;
  assign dout_last = rd_entry.last;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a payload scoreboard.
// Inputs change #1 after posedge; outputs are observed on the falling edge.
// Timeout is shortened so the stall case stays brief.
module tb_uart_frame_parser;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       dout_ready = 1'b0;
  logic [7:0] dout;
  logic       dout_last;
  logic       dout_valid;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_count;

  int         tests = 0;
  int         fails = 0;
  int         ok_seen = 0;
  int         err_seen = 0;
  int         accepts = 0;
  int         err_exp = 0;
  logic [8:0] sbq[$];
  logic       hold_vld = 1'b0;
  logic [8:0] hold_val = '0;

  uart_frame_parser #(.MAX_LEN(16), .DEPTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts status pulses, checks hold stability, pops the scoreboard.
  always @(negedge clk) begin
    if (frame_ok)  ok_seen++;
    if (frame_err) err_seen++;
    if (!rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("hold_valid", dout_valid, 1);
        check("hold_data", {dout, dout_last}, hold_val);
      end
      if (dout_valid && dout_ready) begin
        accepts++;
        check("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) check("payload", {dout, dout_last}, sbq.pop_front());
      end
      hold_vld = dout_valid && !dout_ready;
      hold_val = {dout, dout_last};
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    din = b;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic good_frame(input int len, input logic [7:0] seed);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'(len);
    send(8'hA5);
    send(8'(len));
    for (int i = 0; i < len; i++) begin
      b = seed + 8'(i);
      c = c ^ b;
      sbq.push_back({b, i == len - 1});
      send(b);
    end
    send(c);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sbq.size() != 0 || dout_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, sbq.size(), 0);
  endtask

  initial begin
    int ok0, err0, acc0, first, cnt;
    logic vld_seen;

    // Reset state
    idle(3);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_dout", {dout, dout_last}, 0);
    rst = 1'b1;
    dout_ready = 1'b1;
    idle(2);

    // Good frame with exact output timing
    sbq.push_back({8'h11, 1'b0});
    sbq.push_back({8'h22, 1'b0});
    sbq.push_back({8'h33, 1'b1});
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    @(negedge clk);
    check("g1_frame_ok", frame_ok, 1);
    check("g1_valid0", dout_valid, 1);
    check("g1_byte0", {dout, dout_last}, {8'h11, 1'b0});
    @(negedge clk);
    check("g1_ok_once", frame_ok, 0);
    check("g1_byte1", {dout, dout_last}, {8'h22, 1'b0});
    @(negedge clk);
    check("g1_byte2", {dout, dout_last}, {8'h33, 1'b1});
    @(negedge clk);
    check("g1_empty", dout_valid, 0);
    check("g1_err_count", err_count, 0);
    idle(1);

    // Bad checksum, then a good one-byte frame
    err0 = err_seen;
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
    idle(3);
    err_exp++;
    check("badcs_err_pulse", err_seen - err0, 1);
    check("badcs_err_count", err_count, err_exp);
    good_frame(1, 8'h5A);
    wait_drain("badcs_next_drain");

    // Garbage and length errors
    err0 = err_seen;
    send(8'h3C); send(8'h3C);
    idle(3);
    check("garbage_no_err", err_seen - err0, 0);
    send(8'hA5); send(8'h00);
    idle(3);
    check("len0_err", err_seen - err0, 1);
    send(8'hA5); send(8'h11);
    idle(3);
    check("len17_err", err_seen - err0, 2);
    err_exp += 2;
    check("len_err_count", err_count, err_exp);

    // Backpressure: fill the buffer, overflow a third frame, then drain
    dout_ready = 1'b0;
    ok0 = ok_seen;
    good_frame(16, 8'h40);
    good_frame(16, 8'h80);
    idle(3);
    check("full_two_ok", ok_seen - ok0, 2);
    check("full_valid", dout_valid, 1);
    check("full_head", {dout, dout_last}, {8'h40, 1'b0});
    err0 = err_seen;
    send(8'hA5); send(8'h01); send(8'h10); send(8'h11);
    idle(3);
    err_exp++;
    check("full_len_err", err_seen - err0, 1);
    check("full_err_count", err_count, err_exp);
    acc0 = accepts;
    dout_ready = 1'b1;
    wait_drain("full_drain");
    check("full_drain_count", accepts - acc0, 32);

    // Timeout mid-payload
    sbq.delete();
    send(8'hA5); send(8'h04); send(8'h01);
    first = -1;
    cnt = 0;
    vld_seen = 1'b0;
    for (int k = 0; k < TO + 6; k++) begin
      @(negedge clk);
      if (frame_err) begin
        if (first < 0) first = k;
        cnt++;
      end
      if (dout_valid) vld_seen = 1'b1;
    end
    err_exp++;
    check("to_cycle", first, TO + 1);
    check("to_pulse_len", cnt, 1);
    check("to_no_output", vld_seen, 0);
    idle(1);
    check("to_err_count", err_count, err_exp);
    good_frame(2, 8'h61);
    wait_drain("to_next_drain");

    // Reset with committed data pending
    dout_ready = 1'b0;
    good_frame(5, 8'hC0);
    idle(2);
    check("rd_pending", dout_valid, 1);
    rst = 1'b0;
    #1;
    check("rd_valid_cleared", dout_valid, 0);
    check("rd_err_cleared", err_count, 0);
    check("rd_dout_cleared", {dout, dout_last}, 0);
    sbq.delete();
    err_exp = 0;
    idle(2);
    rst = 1'b1;
    dout_ready = 1'b1;
    idle(1);
    acc0 = accepts;
    good_frame(3, 8'h21);
    wait_drain("rd_next_drain");
    check("rd_next_count", accepts - acc0, 3);
    check("rd_err_final", err_count, err_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
